// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the RV32 run controller: FSM states and halt causes.
// No logic; latency n/a.
// Backpressure n/a.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        HALT  = 3'd4
    } run_state_t;

    typedef enum logic [2:0] {
        NONE      = 3'd0,
        STOP      = 3'd1,
        BREAK     = 3'd2,
        LOOP      = 3'd3,
        BUDGET    = 3'd4,
        STEP_DONE = 3'd5
    } halt_cause_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Latency: q updates one cycle after clr/inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] q
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/stop/step sequencer for the single-cycle RV32 core with breakpoint, self-loop and budget halts.
// Latency: pc_en is combinational from state/pc; state and halt_cause change at the next edge.
// Backpressure: stop or a breakpoint gates pc_en in the same cycle so that instruction never retires.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  cont,
    input  logic                  bp_en,
    input  logic [DATA_WIDTH-1:0] bp_addr,
    input  logic [CNT_WIDTH-1:0]  max_cycles,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] next_pc,
    output logic                  cpu_rst,
    output logic                  pc_en,
    output logic                  running,
    output logic                  halted,
    output halt_cause_t           halt_cause,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    run_state_t  state_q,      state_d;
    halt_cause_t halt_cause_q, halt_cause_d;
    logic        skip_bp_q,    skip_bp_d;

    logic                 bp_hit;
    logic                 loop_hit;
    logic                 budget_hit;
    logic [CNT_WIDTH-1:0] cnt_plus1;

    // skip_bp lets a cont resume from the very PC that tripped the breakpoint.
    assign bp_hit     = bp_en && (pc == bp_addr) && !skip_bp_q;
    assign loop_hit   = (next_pc == pc);
    assign cnt_plus1  = cycle_count + CNT_WIDTH'(1);
    assign budget_hit = (max_cycles != '0) && (cnt_plus1 == max_cycles);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            halt_cause_q <= NONE;
            skip_bp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_cause_q <= halt_cause_d;
            skip_bp_q    <= skip_bp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        halt_cause_d = halt_cause_q;
        skip_bp_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            CLEAR: begin
                state_d      = RUN;
                halt_cause_d = NONE;
            end
            RUN: begin
                if (stop) begin
                    state_d      = HALT;
                    halt_cause_d = STOP;
                end else if (bp_hit) begin
                    state_d      = HALT;
                    halt_cause_d = BREAK;
                end else if (loop_hit) begin
                    state_d      = HALT;
                    halt_cause_d = LOOP;
                end else if (budget_hit) begin
                    state_d      = HALT;
                    halt_cause_d = BUDGET;
                end
            end
            STEP: begin
                state_d      = HALT;
                halt_cause_d = STEP_DONE;
            end
            HALT: begin
                if (start) begin
                    state_d = CLEAR;
                end else if (cont) begin
                    state_d   = RUN;
                    skip_bp_d = 1'b1;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cpu_rst = (state_q == CLEAR);
        running = (state_q == RUN) || (state_q == STEP);
        halted  = (state_q == HALT);
        pc_en   = ((state_q == RUN) && !stop && !bp_hit) || (state_q == STEP);
    end

    assign halt_cause = halt_cause_q;

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q == CLEAR),
        .inc (pc_en),
        .q   (cycle_count)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench: a behavioural pc_reg + program table stands in for the core around cpu_run_ctrl.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stop, step, cont, bp_en;
    logic [31:0] bp_addr, max_cycles;
    logic [31:0] pc = 32'h0;
    logic [31:0] next_pc;
    logic        cpu_rst, pc_en, running, halted;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_count;

    // prog_mode 0: straight-line code ending in "beq x0,x0,0" at 0x20; 1: no self-loop.
    int unsigned prog_mode = 0;
    int n_pass  = 0;
    int n_total = 0;
    int pulses;

    always #5 clk = ~clk;

    assign next_pc = (prog_mode == 0 && pc == 32'h20) ? pc : pc + 32'd4;

    always @(posedge clk) begin
        if (cpu_rst)    pc <= 32'h0;
        else if (pc_en) pc <= next_pc;
    end

    cpu_run_ctrl #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .cont       (cont),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .max_cycles (max_cycles),
        .pc         (pc),
        .next_pc    (next_pc),
        .cpu_rst    (cpu_rst),
        .pc_en      (pc_en),
        .running    (running),
        .halted     (halted),
        .halt_cause (halt_cause),
        .cycle_count(cycle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Runs until halted (bounded), counting pc_en pulses; an expired bound shows up as a halted check.
    task automatic run_to_halt(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (halted) break;
            if (pc_en) n++;
            cyc();
        end
        chk({tag, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; cont = 1'b0;
        bp_en = 1'b0; bp_addr = 32'h0; max_cycles = 32'd0;
        cyc(); cyc();
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_halted",  {31'd0, halted},  32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("rst_pc_en",   {31'd0, pc_en},   32'd0);
        chk("rst_cause",   {29'd0, halt_cause}, 32'd0);
        chk("rst_count",   cycle_count, 32'd0);
        rst = 1'b0;
        cyc();

        // Free run to the self-loop
        pulse_start();
        chk("clr_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("clr_running", {31'd0, running}, 32'd0);
        cyc();
        chk("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        chk("run_running", {31'd0, running}, 32'd1);
        chk("run_pc0",     pc, 32'h0);
        run_to_halt("loop", pulses);
        chk("loop_cause",  {29'd0, halt_cause}, 32'd3);
        chk("loop_count",  cycle_count, 32'd9);
        chk("loop_pulses", pulses, 32'd9);
        chk("loop_pc",     pc, 32'h20);

        // Breakpoint at 0x0C, then continue past it
        bp_en = 1'b1; bp_addr = 32'h0C;
        pulse_start();
        run_to_halt("bp", pulses);
        chk("bp_cause", {29'd0, halt_cause}, 32'd2);
        chk("bp_pc",    pc, 32'h0C);
        chk("bp_count", cycle_count, 32'd3);
        chk("bp_pc_en", {31'd0, pc_en}, 32'd0);
        cont = 1'b1;
        cyc();
        cont = 1'b0;
        chk("cont_pc_en", {31'd0, pc_en}, 32'd1);
        cyc();
        chk("cont_pc", pc, 32'h10);
        run_to_halt("cont", pulses);
        chk("cont_cause", {29'd0, halt_cause}, 32'd3);
        chk("cont_count", cycle_count, 32'd9);

        // Back to the breakpoint, then three single steps
        pulse_start();
        run_to_halt("bp2", pulses);
        chk("bp2_pc", pc, 32'h0C);
        for (int k = 0; k < 3; k++) begin
            pulses = 0;
            step = 1'b1;
            cyc();
            step = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (pc_en) pulses++;
                cyc();
            end
            chk("step_pulses", pulses, 32'd1);
            chk("step_pc",     pc, 32'h0C + 32'd4 * (k + 1));
            chk("step_cause",  {29'd0, halt_cause}, 32'd5);
        end
        chk("step_count", cycle_count, 32'd6);

        // Instruction budget on a program with no self-loop
        bp_en = 1'b0; prog_mode = 1; max_cycles = 32'd5;
        pulse_start();
        run_to_halt("bud", pulses);
        chk("bud_cause",  {29'd0, halt_cause}, 32'd4);
        chk("bud_count",  cycle_count, 32'd5);
        chk("bud_pulses", pulses, 32'd5);
        chk("bud_pc",     pc, 32'h14);

        // stop coinciding with breakpoint and self-loop at 0x20
        prog_mode = 0; max_cycles = 32'd0; bp_en = 1'b1; bp_addr = 32'h20;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (pc == 32'h20 && running) break;
            cyc();
        end
        chk("pri_at_pc", pc, 32'h20);
        stop = 1'b1;
        #1;
        chk("pri_pc_en", {31'd0, pc_en}, 32'd0);
        cyc();
        stop = 1'b0;
        chk("pri_halted", {31'd0, halted}, 32'd1);
        chk("pri_cause",  {29'd0, halt_cause}, 32'd1);
        chk("pri_count",  cycle_count, 32'd8);

        // rst in the middle of a run
        bp_en = 1'b0; prog_mode = 1;
        pulse_start();
        cyc(); cyc(); cyc();
        chk("mid_running", {31'd0, running}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_running0", {31'd0, running}, 32'd0);
        chk("mid_halted",   {31'd0, halted},  32'd0);
        chk("mid_cpu_rst",  {31'd0, cpu_rst}, 32'd0);
        chk("mid_pc_en",    {31'd0, pc_en},   32'd0);
        chk("mid_cause",    {29'd0, halt_cause}, 32'd0);
        chk("mid_count",    cycle_count, 32'd0);

        // Step from IDLE, then start+step together in HALT: start wins
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        chk("idle_step_cause", {29'd0, halt_cause}, 32'd5);
        chk("idle_step_count", cycle_count, 32'd1);
        start = 1'b1; step = 1'b1;
        cyc();
        start = 1'b0; step = 1'b0;
        chk("both_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("both_running", {31'd0, running}, 32'd0);
        cyc();
        chk("both_run",   {31'd0, running}, 32'd1);
        chk("both_count", cycle_count, 32'd0);
        chk("both_pc",    pc, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
